// File: rtl/mem_bus_arbiter.sv
// Arbitrates the F-stage fetch and M-stage data requesters onto one memory bus with an ack watchdog.
// Define MEM_BUS_ARB_RR_EN for round-robin tie-breaking; the default gives data fixed priority.
module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_req,
    input  logic [AW-1:0]   inst_addr,
    output logic [DW-1:0]   inst_rdata,
    output logic            inst_ready,
    output logic            inst_err,
    input  logic            data_req,
    input  logic            data_we,
    input  logic [DW/8-1:0] data_be,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW-1:0]   data_wdata,
    output logic [DW-1:0]   data_rdata,
    output logic            data_ready,
    output logic            data_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack
);

    localparam int BW = DW / 8;
    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   wd_q, wd_d, wd_inc;
    logic            grant_data_q, grant_data_d;
    logic            pick_data;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [BW-1:0]   mem_be_q, mem_be_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]   inst_rdata_q, inst_rdata_d;
    logic            inst_ready_q, inst_ready_d;
    logic            inst_err_q, inst_err_d;
    logic [DW-1:0]   data_rdata_q, data_rdata_d;
    logic            data_ready_q, data_ready_d;
    logic            data_err_q, data_err_d;
`ifdef MEM_BUS_ARB_RR_EN
    logic            last_data_q, last_data_d;
`endif

    always_comb begin
`ifdef MEM_BUS_ARB_RR_EN
        // On a tie the side not served last wins; reset value 0 means "inst was last".
        pick_data = data_req && (!inst_req || !last_data_q);
`else
        pick_data = data_req;
`endif
    end

    always_comb begin
        state_d      = state_q;
        wd_inc       = wd_q + 1'b1;
        wd_d         = wd_q;
        grant_data_d = grant_data_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_ready_d = 1'b0;
        data_ready_d = 1'b0;
        inst_err_d   = 1'b0;
        data_err_d   = 1'b0;
`ifdef MEM_BUS_ARB_RR_EN
        last_data_d  = last_data_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (inst_req || data_req) begin
                    state_d      = BUSY;
                    wd_d         = '0;
                    grant_data_d = pick_data;
                    mem_req_d    = 1'b1;
                    mem_we_d     = pick_data ? data_we : 1'b0;
                    mem_be_d     = pick_data ? data_be : '1;
                    mem_addr_d   = pick_data ? data_addr : inst_addr;
                    mem_wdata_d  = pick_data ? data_wdata : '0;
`ifdef MEM_BUS_ARB_RR_EN
                    last_data_d  = pick_data;
`endif
                end
            end
            BUSY: begin
                wd_d = wd_inc;
                if (mem_ack) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (grant_data_q) begin
                        data_rdata_d = mem_rdata;
                        data_ready_d = 1'b1;
                    end else begin
                        inst_rdata_d = mem_rdata;
                        inst_ready_d = 1'b1;
                    end
                end else if (wd_inc == TIMEOUT_CNT) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (grant_data_q) begin
                        data_rdata_d = '0;
                        data_ready_d = 1'b1;
                        data_err_d   = 1'b1;
                    end else begin
                        inst_rdata_d = '0;
                        inst_ready_d = 1'b1;
                        inst_err_d   = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            wd_q         <= '0;
            grant_data_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_rdata_q <= '0;
            inst_ready_q <= 1'b0;
            inst_err_q   <= 1'b0;
            data_rdata_q <= '0;
            data_ready_q <= 1'b0;
            data_err_q   <= 1'b0;
`ifdef MEM_BUS_ARB_RR_EN
            last_data_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wd_q         <= wd_d;
            grant_data_q <= grant_data_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            inst_ready_q <= inst_ready_d;
            inst_err_q   <= inst_err_d;
            data_rdata_q <= data_rdata_d;
            data_ready_q <= data_ready_d;
            data_err_q   <= data_err_d;
`ifdef MEM_BUS_ARB_RR_EN
            last_data_q  <= last_data_d;
`endif
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign inst_ready = inst_ready_q;
    assign inst_err   = inst_err_q;
    assign data_rdata = data_rdata_q;
    assign data_ready = data_ready_q;
    assign data_err   = data_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed cycle-by-cycle bench for mem_bus_arbiter; inputs driven and outputs sampled on the falling edge.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    logic        inst_err;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        data_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_cmp = 0;
    int n_bad = 0;

    mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(4), .TW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_ready (inst_ready),
        .inst_err   (inst_err),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_be    (data_be),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_ready (data_ready),
        .data_err   (data_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " mem_req"},    32'(mem_req),    32'h0);
        check_eq({tag, " mem_we"},     32'(mem_we),     32'h0);
        check_eq({tag, " mem_be"},     32'(mem_be),     32'h0);
        check_eq({tag, " mem_addr"},   mem_addr,        32'h0);
        check_eq({tag, " mem_wdata"},  mem_wdata,       32'h0);
        check_eq({tag, " inst_rdata"}, inst_rdata,      32'h0);
        check_eq({tag, " inst_ready"}, 32'(inst_ready), 32'h0);
        check_eq({tag, " inst_err"},   32'(inst_err),   32'h0);
        check_eq({tag, " data_rdata"}, data_rdata,      32'h0);
        check_eq({tag, " data_ready"}, 32'(data_ready), 32'h0);
        check_eq({tag, " data_err"},   32'(data_err),   32'h0);
    endtask

    initial begin
        rst        = 1'b0;
        inst_req   = 1'b0;
        inst_addr  = '0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_be    = '0;
        data_addr  = '0;
        data_wdata = '0;
        mem_rdata  = '0;
        mem_ack    = 1'b0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // single fetch, ack at cycle 3
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            inst_req  = (c <= 4);
            inst_addr = 32'h0040_0000;
            mem_ack   = (c == 3);
            mem_rdata = (c == 3) ? 32'h2402_000A : 32'hBAD0_BAD0;
            check_eq($sformatf("t1 mem_req c%0d", c),    32'(mem_req),    32'(c >= 1 && c <= 3));
            check_eq($sformatf("t1 inst_ready c%0d", c), 32'(inst_ready), 32'(c == 4));
            check_eq($sformatf("t1 data_ready c%0d", c), 32'(data_ready), 32'h0);
            if (c == 1) begin
                check_eq("t1 mem_addr", mem_addr,     32'h0040_0000);
                check_eq("t1 mem_we",   32'(mem_we), 32'h0);
                check_eq("t1 mem_be",   32'(mem_be), 32'hF);
            end
            if (c == 4) begin
                check_eq("t1 inst_rdata", inst_rdata,    32'h2402_000A);
                check_eq("t1 inst_err",   32'(inst_err), 32'h0);
            end
        end

        // tie at cycle 0: data served first, then inst
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            data_req   = (c <= 3);
            data_we    = 1'b1;
            data_be    = 4'hF;
            data_addr  = 32'h1001_0004;
            data_wdata = 32'hDEAD_BEEF;
            inst_req   = (c <= 6);
            inst_addr  = 32'h0040_0004;
            mem_ack    = (c == 2 || c == 5);
            mem_rdata  = (c == 2) ? 32'hCAFE_0001 : (c == 5) ? 32'h1111_2222 : 32'hBAD0_BAD0;
            check_eq($sformatf("t2 mem_req c%0d", c),    32'(mem_req),    32'(c == 1 || c == 2 || c == 5));
            check_eq($sformatf("t2 data_ready c%0d", c), 32'(data_ready), 32'(c == 3));
            check_eq($sformatf("t2 inst_ready c%0d", c), 32'(inst_ready), 32'(c == 6));
            if (c == 1) begin
                check_eq("t2 data mem_we",    32'(mem_we), 32'h1);
                check_eq("t2 data mem_addr",  mem_addr,    32'h1001_0004);
                check_eq("t2 data mem_wdata", mem_wdata,   32'hDEAD_BEEF);
            end
            if (c == 3) check_eq("t2 data_err", 32'(data_err), 32'h0);
            if (c == 5) begin
                check_eq("t2 inst mem_we",   32'(mem_we), 32'h0);
                check_eq("t2 inst mem_be",   32'(mem_be), 32'hF);
                check_eq("t2 inst mem_addr", mem_addr,    32'h0040_0004);
            end
            if (c == 6) check_eq("t2 inst_rdata", inst_rdata, 32'h1111_2222);
        end

        // timeout abort, then ack exactly on the 4th BUSY cycle; stray ack in RESP at c5
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            data_req   = (c <= 5) || (c >= 7 && c <= 12);
            data_we    = 1'b0;
            data_be    = 4'hF;
            data_addr  = (c <= 6) ? 32'h1001_0008 : 32'h1001_000C;
            data_wdata = '0;
            inst_req   = 1'b0;
            mem_ack    = (c == 5 || c == 11);
            mem_rdata  = (c == 11) ? 32'h1234_5678 : 32'hFFFF_FFFF;
            check_eq($sformatf("t3 mem_req c%0d", c),    32'(mem_req),
                     32'((c >= 1 && c <= 4) || (c >= 8 && c <= 11)));
            check_eq($sformatf("t3 data_ready c%0d", c), 32'(data_ready), 32'(c == 5 || c == 12));
            check_eq($sformatf("t3 data_err c%0d", c),   32'(data_err),   32'(c == 5));
            if (c == 5)  check_eq("t3 timeout rdata", data_rdata, 32'h0);
            if (c == 12) check_eq("t4 ack-at-limit rdata", data_rdata, 32'h1234_5678);
        end

        // reset while BUSY, stray ack afterwards
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            inst_req  = (c <= 1);
            inst_addr = 32'h0040_0040;
            data_req  = 1'b0;
            rst       = (c != 2);
            mem_ack   = (c == 3);
            mem_rdata = 32'h55AA_55AA;
            if (c == 1) check_eq("t5 mem_req busy", 32'(mem_req), 32'h1);
            if (c == 3) check_all_zero("t5 post-reset");
            if (c >= 4) begin
                check_eq($sformatf("t5 mem_req c%0d", c),    32'(mem_req),    32'h0);
                check_eq($sformatf("t5 inst_ready c%0d", c), 32'(inst_ready), 32'h0);
                check_eq($sformatf("t5 inst_rdata c%0d", c), inst_rdata,      32'h0);
            end
        end

        // byte store: enables pass through, fetch side stays quiet
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rst        = 1'b1;
            inst_req   = 1'b0;
            data_req   = (c <= 3);
            data_we    = 1'b1;
            data_be    = 4'b0010;
            data_addr  = 32'h1001_0001;
            data_wdata = 32'h0000_AB00;
            mem_ack    = (c == 2);
            mem_rdata  = 32'h0000_0000;
            check_eq($sformatf("t6 mem_req c%0d", c),    32'(mem_req),    32'(c == 1 || c == 2));
            check_eq($sformatf("t6 data_ready c%0d", c), 32'(data_ready), 32'(c == 3));
            check_eq($sformatf("t6 inst_ready c%0d", c), 32'(inst_ready), 32'h0);
            if (c == 1) begin
                check_eq("t6 mem_be",    32'(mem_be), 32'h2);
                check_eq("t6 mem_we",    32'(mem_we), 32'h1);
                check_eq("t6 mem_addr",  mem_addr,    32'h1001_0001);
                check_eq("t6 mem_wdata", mem_wdata,   32'h0000_AB00);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
